// File: rtl/branch_pkg.sv
// branch_pkg: opcode/rt codes, 2-bit predictor states and the saturating update rule
package branch_pkg;
  localparam logic [5:0] OP_REGIMM = 6'd1;
  localparam logic [5:0] OP_BEQ    = 6'd4;
  localparam logic [5:0] OP_BNE    = 6'd5;
  localparam logic [5:0] OP_BLEZ   = 6'd6;
  localparam logic [5:0] OP_BGTZ   = 6'd7;
  localparam logic [4:0] RT_BLTZ   = 5'd0;
  localparam logic [4:0] RT_BGEZ   = 5'd1;
  typedef enum logic [1:0] {SN = 2'b00, WN = 2'b01, WT = 2'b10, ST = 2'b11} bht_state_t;
  function automatic bht_state_t bht_next(input bht_state_t s, input logic taken);
    return taken ? (s == ST ? ST : bht_state_t'(s + 2'd1)) : (s == SN ? SN : bht_state_t'(s - 2'd1));
  endfunction
endpackage

// File: rtl/branch_history_table.sv
// branch_history_table: 2-bit saturating predictor table, async read, sync update and reset
module branch_history_table
  import branch_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_state_t       rd_state,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);
  bht_state_t tbl [DEPTH];
  assign rd_state = tbl[rd_idx];
  // reset all entries to weakly-not-taken, otherwise step the addressed entry
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < DEPTH; i++) tbl[i] <= WN;
    else if (we) tbl[wr_idx] <= bht_next(tbl[wr_idx], wr_taken);
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves MIPS-style branches, flags mispredicts, trains a BHT and keeps stats
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [PC_W-1:0]   LookupPC,
  output logic              PredTaken,
  input  logic              ResValid,
  input  logic [PC_W-1:0]   ResPC,
  input  logic [5:0]        Opcode,
  input  logic [4:0]        Rt,
  input  logic [DATA_W-1:0] RD1,
  input  logic [DATA_W-1:0] RD2,
  input  logic              PredIn,
  input  logic [PC_W-1:0]   TargetPC,
  input  logic [PC_W-1:0]   FallPC,
  input  logic              Stall,
  output logic              OutValid,
  output logic              BranchTaken,
  output logic              Mispredict,
  output logic [PC_W-1:0]   RedirectPC,
  output logic [CNT_W-1:0]  BranchCount,
  output logic [CNT_W-1:0]  MispredCount
);
  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic       is_branch, taken, mispred, neg, zero;
  bht_state_t rd_state;
  // signed compares against zero reduce to the sign bit and a zero test
  always_comb begin
    neg       = RD1[DATA_W-1];
    zero      = RD1 == '0;
    is_branch = (Opcode == OP_REGIMM && (Rt == RT_BLTZ || Rt == RT_BGEZ)) || Opcode == OP_BEQ ||
                Opcode == OP_BNE || Opcode == OP_BLEZ || Opcode == OP_BGTZ;
    taken     = Opcode == OP_REGIMM ? (Rt == RT_BLTZ ? neg : Rt == RT_BGEZ ? !neg : 1'b0) :
                Opcode == OP_BEQ    ? RD1 == RD2 :
                Opcode == OP_BNE    ? RD1 != RD2 :
                Opcode == OP_BLEZ   ? neg || zero :
                Opcode == OP_BGTZ   ? !neg && !zero : 1'b0;
    mispred   = ResValid && (taken != PredIn);
  end
  branch_history_table #(.DEPTH(BHT_DEPTH), .IDX_W(IDX_W)) u_bht (
    .clk     (Clk),
    .rst     (Reset),
    .rd_idx  (LookupPC[IDX_W+1:2]),
    .rd_state(rd_state),
    .we      (ResValid && is_branch && !Stall),
    .wr_idx  (ResPC[IDX_W+1:2]),
    .wr_taken(taken)
  );
  assign PredTaken = rd_state[1];
  // result registers and saturating statistics, frozen while stalled
  always_ff @(posedge Clk) begin
    if (Reset) begin
      OutValid     <= 1'b0;
      BranchTaken  <= 1'b0;
      Mispredict   <= 1'b0;
      RedirectPC   <= '0;
      BranchCount  <= '0;
      MispredCount <= '0;
    end else if (!Stall) begin
      OutValid    <= ResValid;
      BranchTaken <= ResValid && taken;
      Mispredict  <= mispred;
      RedirectPC  <= taken ? TargetPC : FallPC;
      if (ResValid && is_branch && BranchCount != CNT_MAX) BranchCount <= BranchCount + CNT_ONE;
      if (mispred && MispredCount != CNT_MAX) MispredCount <= MispredCount + CNT_ONE;
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: scenario tasks plus random traffic checked against a behavioural model
module tb_branch_resolve_unit;
  logic        Clk = 0, Reset = 1, ResValid = 0, PredIn = 0, Stall = 0;
  logic [31:0] LookupPC = 0, ResPC = 0, RD1 = 0, RD2 = 0, TargetPC = 0, FallPC = 0, RedirectPC;
  logic [5:0]  Opcode = 0;
  logic [4:0]  Rt = 0;
  logic        PredTaken, OutValid, BranchTaken, Mispredict;
  logic [3:0]  BranchCount, MispredCount;
  int n_checks = 0, n_fail = 0;
  int m_bht [16];
  bit m_valid, m_taken, m_mis;
  logic [31:0] m_redir;
  int m_bc, m_mc;

  branch_resolve_unit #(.DATA_W(32), .PC_W(32), .BHT_DEPTH(16), .CNT_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .LookupPC(LookupPC), .PredTaken(PredTaken), .ResValid(ResValid),
    .ResPC(ResPC), .Opcode(Opcode), .Rt(Rt), .RD1(RD1), .RD2(RD2), .PredIn(PredIn),
    .TargetPC(TargetPC), .FallPC(FallPC), .Stall(Stall), .OutValid(OutValid),
    .BranchTaken(BranchTaken), .Mispredict(Mispredict), .RedirectPC(RedirectPC),
    .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  always #5 Clk = ~Clk;

  function automatic bit ref_outcome(input logic [5:0] op, input logic [4:0] rt,
                                     input logic [31:0] r1, input logic [31:0] r2, output bit isb);
    int a, b;
    a = $signed(r1);
    b = $signed(r2);
    isb = 1;
    if (op == 1 && rt == 0) return a < 0;
    if (op == 1 && rt == 1) return a >= 0;
    if (op == 4) return a == b;
    if (op == 5) return a != b;
    if (op == 6) return a <= 0;
    if (op == 7) return a > 0;
    isb = 0;
    return 0;
  endfunction

  function automatic bit ref_pred(input logic [31:0] pc);
    return m_bht[pc[5:2]] >= 2;
  endfunction

  task automatic set_in(input bit v, input logic [5:0] op, input logic [4:0] rt, input logic [31:0] r1,
                        input logic [31:0] r2, input bit pin, input logic [31:0] rpc, input bit st, input bit rs);
    ResValid = v; Opcode = op; Rt = rt; RD1 = r1; RD2 = r2; PredIn = pin; ResPC = rpc;
    TargetPC = 32'h100 + rpc; FallPC = rpc + 4; Stall = st; Reset = rs;
  endtask

  task automatic step();
    bit isb, at;
    @(posedge Clk);
    if (Reset) begin
      m_valid = 0; m_taken = 0; m_mis = 0; m_redir = 0; m_bc = 0; m_mc = 0;
      foreach (m_bht[i]) m_bht[i] = 1;
    end else if (!Stall) begin
      at = ResValid && ref_outcome(Opcode, Rt, RD1, RD2, isb);
      m_valid = ResValid;
      m_taken = at;
      m_mis = ResValid && (at != PredIn);
      m_redir = at ? TargetPC : FallPC;
      if (ResValid && isb) begin
        m_bht[ResPC[5:2]] = at ? (m_bht[ResPC[5:2]] == 3 ? 3 : m_bht[ResPC[5:2]] + 1)
                               : (m_bht[ResPC[5:2]] == 0 ? 0 : m_bht[ResPC[5:2]] - 1);
        if (m_bc < 15) m_bc++;
      end
      if (m_mis && m_mc < 15) m_mc++;
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [5:0] op, input logic [4:0] rt, input logic [31:0] r1,
                       input logic [31:0] r2, input bit pin, input logic [31:0] rpc, input bit st, input bit rs);
    set_in(v, op, rt, r1, r2, pin, rpc, st, rs);
    step();
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    drive(1, 4, 0, 1, 1, 0, 0, 0, 1);
    n_checks++; if (OutValid !== 0 || Mispredict !== 0 || BranchTaken !== 0) begin n_fail++;
      $display("FAIL reset_out: got v=%b t=%b m=%b want 0", OutValid, BranchTaken, Mispredict); end
    n_checks++; if (BranchCount !== 0 || MispredCount !== 0 || RedirectPC !== 0) begin n_fail++;
      $display("FAIL reset_cnt: got bc=%0d mc=%0d rpc=%h want 0", BranchCount, MispredCount, RedirectPC); end
    for (int i = 0; i < 16; i++) begin
      LookupPC = i * 4; #1;
      n_checks++; if (PredTaken !== 0) begin n_fail++;
        $display("FAIL reset_pred[%0d]: got %b want 0", i, PredTaken); end
    end
    Reset = 0;
  endtask

  task automatic test_beq();
    do_reset();
    set_in(1, 4, 0, 5, 5, 0, 0, 0, 0);
    TargetPC = 32'h100;
    step();
    n_checks++; if ({OutValid, BranchTaken, Mispredict} !== 3'b111 || RedirectPC !== 32'h100) begin n_fail++;
      $display("FAIL beq_path: got v=%b t=%b m=%b rpc=%h want 1 1 1 00000100", OutValid, BranchTaken, Mispredict, RedirectPC); end
    LookupPC = 0; #1;
    n_checks++; if (PredTaken !== 1 || m_bht[0] != 2) begin n_fail++;
      $display("FAIL beq_bht: got pred=%b want 1 (WT)", PredTaken); end
  endtask

  task automatic test_saturation();
    do_reset();
    repeat (3) drive(1, 4, 0, 7, 7, 0, 32'h40, 0, 0);
    LookupPC = 32'h40; #1;
    n_checks++; if (PredTaken !== 1 || m_bht[0] != 3) begin n_fail++;
      $display("FAIL sat_taken: got pred=%b want 1", PredTaken); end
    repeat (2) drive(1, 4, 0, 7, 8, 1, 32'h40, 0, 0);
    LookupPC = 32'h40; #1;
    n_checks++; if (PredTaken !== 0 || m_bht[0] != 1) begin n_fail++;
      $display("FAIL sat_not_taken: got pred=%b want 0", PredTaken); end
  endtask

  task automatic test_signed();
    logic [31:0] r1 [4] = '{32'h80000000, 32'h0, 32'h0, 32'h0};
    logic [5:0] op [4] = '{6'd7, 6'd6, 6'd1, 6'd1};
    logic [4:0] rt [4] = '{5'd0, 5'd0, 5'd1, 5'd2};
    bit want [4] = '{0, 1, 1, 0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, op[i], rt[i], r1[i], 32'h0, 0, 32'h10, 0, 0);
      n_checks++; if (BranchTaken !== want[i] || BranchTaken !== m_taken) begin n_fail++;
        $display("FAIL signed[%0d]: got taken=%b want %b", i, BranchTaken, want[i]); end
    end
    LookupPC = 32'h10; #1;
    n_checks++; if (PredTaken !== ref_pred(32'h10) || m_bht[4] != 2) begin n_fail++;
      $display("FAIL signed_bht: got pred=%b want %b", PredTaken, ref_pred(32'h10)); end
    n_checks++; if (BranchCount !== 3) begin n_fail++;
      $display("FAIL signed_count: got %0d want 3", BranchCount); end
  endtask

  task automatic test_nonbranch();
    int bc, mc;
    bc = m_bc; mc = m_mc;
    drive(1, 6'd35, 0, 0, 0, 1, 32'h20, 0, 0);
    n_checks++; if (Mispredict !== 1 || RedirectPC !== 32'h24 || BranchTaken !== 0) begin n_fail++;
      $display("FAIL nonbranch: got m=%b rpc=%h t=%b want 1 00000024 0", Mispredict, RedirectPC, BranchTaken); end
    n_checks++; if (int'(BranchCount) != bc || int'(MispredCount) != mc + 1) begin n_fail++;
      $display("FAIL nonbranch_cnt: got bc=%0d mc=%0d want %0d %0d", BranchCount, MispredCount, bc, mc + 1); end
  endtask

  task automatic test_stall_reset();
    drive(1, 4, 0, 3, 3, 0, 32'h8, 0, 0);
    drive(1, 5, 0, 3, 4, 0, 32'h8, 1, 0);
    n_checks++; if (OutValid !== 1 || BranchTaken !== 1 || Mispredict !== 1 || RedirectPC !== 32'h108) begin n_fail++;
      $display("FAIL stall_out: got v=%b t=%b m=%b rpc=%h want 1 1 1 00000108", OutValid, BranchTaken, Mispredict, RedirectPC); end
    n_checks++; if (int'(BranchCount) != m_bc || int'(MispredCount) != m_mc) begin n_fail++;
      $display("FAIL stall_cnt: got bc=%0d mc=%0d want %0d %0d", BranchCount, MispredCount, m_bc, m_mc); end
    LookupPC = 32'h8; #1;
    n_checks++; if (PredTaken !== 1) begin n_fail++;
      $display("FAIL stall_bht: got pred=%b want 1", PredTaken); end
    drive(1, 4, 0, 3, 3, 1, 32'hc, 0, 0);
    drive(1, 4, 0, 3, 3, 0, 32'hc, 1, 1);
    n_checks++; if (OutValid !== 0 || BranchCount !== 0) begin n_fail++;
      $display("FAIL reset_inflight: got v=%b bc=%0d want 0 0", OutValid, BranchCount); end
    for (int i = 0; i < 16; i++) begin
      LookupPC = i * 4; #1;
      n_checks++; if (PredTaken !== 0) begin n_fail++;
        $display("FAIL reset_wn[%0d]: got %b want 0", i, PredTaken); end
    end
    Reset = 0;
  endtask

  task automatic test_counter_sat();
    do_reset();
    for (int i = 0; i < 20; i++) drive(1, 5, 0, i, 0, 1, i * 4, 0, 0);
    n_checks++; if (BranchCount !== 4'd15 || int'(BranchCount) != m_bc) begin n_fail++;
      $display("FAIL cnt_sat: got %0d want 15", BranchCount); end
  endtask

  task automatic test_same_index();
    do_reset();
    drive(1, 4, 0, 1, 1, 0, 32'h18, 0, 0);
    set_in(1, 4, 0, 1, 2, 1, 32'h18, 0, 0);
    LookupPC = 32'h18; #1;
    n_checks++; if (PredTaken !== 1) begin n_fail++;
      $display("FAIL same_idx_old: got %b want 1", PredTaken); end
    step();
    n_checks++; if (PredTaken !== 0) begin n_fail++;
      $display("FAIL same_idx_new: got %b want 0", PredTaken); end
  endtask

  task automatic test_random();
    logic [31:0] pool [5] = '{32'h0, 32'h1, 32'hffffffff, 32'h80000000, 32'h7fffffff};
    logic [5:0] ops [7] = '{6'd0, 6'd1, 6'd2, 6'd4, 6'd5, 6'd6, 6'd7};
    logic [31:0] r1, r2;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r1 = $urandom_range(0, 2) == 0 ? $urandom : pool[$urandom_range(0, 4)];
      r2 = $urandom_range(0, 1) == 0 ? r1 : pool[$urandom_range(0, 4)];
      set_in($urandom_range(0, 3) != 0, ops[$urandom_range(0, 6)], 5'($urandom_range(0, 2)), r1, r2,
             1'($urandom), {26'($urandom), 4'($urandom), 2'b00}, $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
      LookupPC = $urandom; #1;
      n_checks++; if (PredTaken !== ref_pred(LookupPC)) begin n_fail++;
        $display("FAIL rnd_pred[%0d]: got %b want %b", n, PredTaken, ref_pred(LookupPC)); end
      step();
      n_checks++; if (OutValid !== m_valid || BranchTaken !== m_taken || Mispredict !== m_mis) begin n_fail++;
        $display("FAIL rnd_out[%0d]: got %b%b%b want %b%b%b", n, OutValid, BranchTaken, Mispredict, m_valid, m_taken, m_mis); end
      if (m_mis) begin
        n_checks++; if (RedirectPC !== m_redir) begin n_fail++;
          $display("FAIL rnd_redirect[%0d]: got %h want %h", n, RedirectPC, m_redir); end
      end
      n_checks++; if (int'(BranchCount) != m_bc || int'(MispredCount) != m_mc) begin n_fail++;
        $display("FAIL rnd_cnt[%0d]: got %0d %0d want %0d %0d", n, BranchCount, MispredCount, m_bc, m_mc); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_beq();
    test_saturation();
    test_signed();
    test_nonbranch();
    test_stall_reset();
    test_counter_sat();
    test_same_index();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the operand width for RD1/RD2.
REQ-002 SHALL have parameter PC_W, default 32, meaning the PC and target address width.
REQ-003 SHALL have parameter BHT_DEPTH, default 16, meaning the number of 2-bit predictor entries; it must be a power of 2 and at least 2.
REQ-004 SHALL have parameter CNT_W, default 16, meaning the width of the statistics counters.
REQ-005 SHALL use one clock, Clk, with a synchronous active-high reset, Reset; all state SHALL update on the rising edge of Clk.
REQ-006 SHALL have the following ports, one per line (name, direction, width, meaning):
- Clk  in  1  clock
- Reset  in  1  synchronous active-high reset
- LookupPC  in  PC_W  fetch-stage PC
- PredTaken  out  1  combinational prediction for LookupPC
- ResValid  in  1  resolve-stage instruction valid
- ResPC  in  PC_W  PC of the resolving instruction
- Opcode  in  6  instruction[31:26]
- Rt  in  5  instruction[20:16]
- RD1  in  DATA_W  operand 1
- RD2  in  DATA_W  operand 2
- PredIn  in  1  prediction carried down the pipe with this instruction
- TargetPC  in  PC_W  branch target
- FallPC  in  PC_W  PC+4 of this instruction
- Stall  in  1  freeze the unit
- OutValid  out  1  registered result valid
- BranchTaken  out  1  registered actual outcome
- Mispredict  out  1  registered flush request
- RedirectPC  out  PC_W  registered correct next PC
- BranchCount  out  CNT_W  number of resolved branches
- MispredCount  out  CNT_W  number of mispredictions

Function
REQ-007 SHALL classify branches, with all comparisons signed two's complement over DATA_W:
- Opcode=1, Rt=0 -> bltz: taken when RD1<0.
- Opcode=1, Rt=1 -> bgez: taken when RD1>=0.
- Opcode=4 -> beq: taken when RD1==RD2.
- Opcode=5 -> bne: taken when RD1!=RD2.
- Opcode=6 -> blez: taken when RD1<=0.
- Opcode=7 -> bgtz: taken when RD1>0.
- Any other Opcode/Rt combination is not a branch (IsBranch=0) and its actual outcome is not taken.
REQ-008 SHALL compute the outcome combinationally and register it, giving 1-cycle latency from ResValid to OutValid.
REQ-009 SHALL assert Mispredict when ResValid is high and the actual outcome differs from PredIn; this includes a non-branch instruction with PredIn=1.
REQ-010 SHALL set RedirectPC to TargetPC when the outcome is taken and to FallPC otherwise; the value is meaningful only while Mispredict is high.
REQ-011 SHALL, when ResValid is low and Stall is low, register OutValid=0, Mispredict=0 and BranchTaken=0 on the next edge.
REQ-012 SHALL, while Stall is high, hold all output registers, the BHT and both counters unchanged, ignoring ResValid.
REQ-013 SHALL index the BHT by PC[log2(BHT_DEPTH)+1:2] for both lookup and update.
REQ-014 SHALL give each BHT entry the states SN=00, WN=01, WT=10 and ST=11; PredTaken is the entry's MSB.
REQ-015 SHALL update the BHT entry only when ResValid=1, IsBranch=1 and Stall=0:
- taken: SN->WN->WT->ST, saturating at ST.
- not taken: ST->WT->WN->SN, saturating at SN.
REQ-016 SHALL return the pre-update entry value to a lookup that hits the same index as a same-cycle update; there is no bypass.
REQ-017 SHALL increment BranchCount on each accepted branch and MispredCount on each accepted mispredict; both saturate at all-ones and never wrap.

Reset
REQ-018 SHALL, while Reset is high, clear OutValid, BranchTaken, Mispredict, RedirectPC, BranchCount and MispredCount to 0 on the next edge.
REQ-019 SHALL, while Reset is high, set every BHT entry to WN (01) on the same edge.
REQ-020 SHALL give Reset priority over Stall and ResValid; an in-flight result is discarded.
REQ-021 SHALL hold PredTaken at 0 after reset until the first update, because WN has MSB 0.

Structure
REQ-022 SHALL place the opcode constants (1, 4, 5, 6, 7), the Rt codes (0, 1) and the 2-bit counter state encodings in shared package branch_pkg.
REQ-023 SHALL implement the predictor table as one sub-module, branch_history_table, with a combinational read port, a synchronous write port and a synchronous reset of all entries.
REQ-024 SHALL keep the outcome comparison combinational inside branch_resolve_unit.

Verification
REQ-025 SHALL cover the beq reset path: after reset, ResValid=1, Opcode=4, RD1=RD2=5, PredIn=0, TargetPC=0x100 -> next cycle OutValid=1, BranchTaken=1, Mispredict=1, RedirectPC=0x100, and entry WN->WT.
REQ-026 SHALL cover saturation: three taken beq at ResPC=0x40 -> entry ST, PredTaken=1 for LookupPC=0x40; then two not-taken -> WN, PredTaken=0.
REQ-027 SHALL cover signed compares at DATA_W=32:
- bgtz RD1=0x80000000 -> not taken.
- blez RD1=0 -> taken.
- bgez (Opcode=1, Rt=1) RD1=0 -> taken.
- Opcode=1, Rt=2 -> not a branch, no BHT change.
REQ-028 SHALL cover a non-branch with PredIn=1 and FallPC=0x24 -> Mispredict=1, RedirectPC=0x24, BranchCount unchanged, MispredCount +1.
REQ-029 SHALL cover Stall and Reset: Stall=1 with a valid bne -> outputs and counters frozen; Reset asserted in the cycle after a valid branch -> OutValid=0 and all entries WN next cycle.
REQ-030 SHALL cover counter saturation and same-index access: with CNT_W=4, 20 branches -> BranchCount=15; a same-cycle lookup and update at one index -> PredTaken shows the old value.
